// File: rtl/tap_sequencer.sv
// ============================================================================
// Module   : tap_sequencer
// Brief    : Machine-cycle source with NTAPS delayed taps spaced S=speed+1
//            ticks apart; optional long cycles under TAP_SEQUENCER_LONG_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tap_sequencer #(
    parameter int NTAPS = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       speed,
    input  logic             ilong,
    input  logic             hold,
    output logic             src,
    output logic [NTAPS-1:0] tap,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [6:0] C_HALF_N = 7'(NTAPS);

    state_t           r_state;
    state_t           w_state_n;
    logic [5:0]       r_c;
    logic [5:0]       w_c_n;
    logic [2:0]       r_s;
    logic [2:0]       w_s_n;
    logic [6:0]       w_h_cur;
    logic [6:0]       w_h_n;
    logic [6:0]       w_c7_n;
    logic             w_last;
    logic             w_load;
    logic             w_run_n;
    logic             w_src_n;
    logic             w_done_n;
    logic [NTAPS-1:0] w_tap_n;

`ifdef TAP_SEQUENCER_LONG_EN
    localparam logic [6:0] C_HALF_L = 7'(NTAPS + 2);

    logic r_long;
    logic w_long_n;

    assign w_h_cur = r_long   ? C_HALF_L * {4'd0, r_s}   : C_HALF_N * {4'd0, r_s};
    assign w_h_n   = w_long_n ? C_HALF_L * {4'd0, w_s_n} : C_HALF_N * {4'd0, w_s_n};
`else
    logic w_unused_ilong;

    assign w_unused_ilong = ilong;
    assign w_h_cur        = C_HALF_N * {4'd0, r_s};
    assign w_h_n          = C_HALF_N * {4'd0, w_s_n};
`endif

    assign w_last = (r_state == ST_RUN) && ({1'b0, r_c} == ((w_h_cur << 1) - 7'd1));

    // Cycle boundaries are the only points where start is sampled and S/ilong relatched.
    always_comb begin
        w_load    = 1'b0;
        w_state_n = r_state;
        w_c_n     = 6'd0;
        w_s_n     = r_s;
`ifdef TAP_SEQUENCER_LONG_EN
        w_long_n  = r_long;
`endif
        case (r_state)
            ST_IDLE: begin
                if (start) w_load = 1'b1;
            end
            ST_RUN: begin
                if (w_last) begin
                    if (hold)       w_state_n = ST_HOLD;
                    else if (start) w_load    = 1'b1;
                    else            w_state_n = ST_IDLE;
                end else begin
                    w_c_n = r_c + 6'd1;
                end
            end
            ST_HOLD: begin
                if (!hold) begin
                    if (start) w_load    = 1'b1;
                    else       w_state_n = ST_IDLE;
                end
            end
            default: w_state_n = ST_IDLE;
        endcase
        if (w_load) begin
            w_state_n = ST_RUN;
            w_c_n     = 6'd0;
            w_s_n     = {1'b0, speed} + 3'd1;
`ifdef TAP_SEQUENCER_LONG_EN
            w_long_n  = ilong;
`endif
        end
    end

    // Outputs are decoded from the next count so they are registered with it.
    assign w_run_n  = (w_state_n == ST_RUN);
    assign w_c7_n   = {1'b0, w_c_n};
    assign w_src_n  = w_run_n && (w_c7_n < w_h_n);
    assign w_done_n = w_run_n && (w_c7_n == ((w_h_n << 1) - 7'd1));

    for (genvar k = 0; k < NTAPS; k++) begin : g_tap
        logic [6:0] w_off;
        assign w_off      = 7'(k + 1) * {4'd0, w_s_n};
        assign w_tap_n[k] = w_run_n && (w_c7_n >= w_off) && (w_c7_n < (w_h_n + w_off));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_c     <= 6'd0;
            r_s     <= 3'd0;
`ifdef TAP_SEQUENCER_LONG_EN
            r_long  <= 1'b0;
`endif
            src     <= 1'b0;
            tap     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_c     <= w_c_n;
            r_s     <= w_s_n;
`ifdef TAP_SEQUENCER_LONG_EN
            r_long  <= w_long_n;
`endif
            src     <= w_src_n;
            tap     <= w_tap_n;
            busy    <= (w_state_n != ST_IDLE);
            done    <= w_done_n;
        end
    end

endmodule

`default_nettype wire

// File: doc/tap_sequencer.md
TAP_SEQUENCER -- requirements
Module: tap_sequencer

Interface
REQ-001 SHALL have parameter: NTAPS, 5, number of tap outputs (legal 1..5).
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  request a machine cycle; level-sensitive, sampled at cycle boundaries.
REQ-005 SHALL have port: speed  input  2  tap spacing select; S = speed+1 clk ticks per tap.
REQ-006 SHALL have port: ilong  input  1  long-cycle request; extends each half-cycle by 2*S ticks.
REQ-007 SHALL have port: hold  input  1  freeze at end of cycle while high.
REQ-008 SHALL have port: src  output  1  cycle source level (undelayed phase).
REQ-009 SHALL have port: tap  output  NTAPS  tap[k] = src delayed (k+1)*S ticks.
REQ-010 SHALL have port: busy  output  1  high in RUN and HOLD.
REQ-011 SHALL have port: done  output  1  one-tick pulse on last tick of a cycle.

Function
REQ-012 SHALL implement states IDLE, RUN, HOLD; 6-bit tick counter c; all outputs registered.
REQ-013 SHALL, in IDLE with start=1 at an edge, latch S and ilong, set c=0 and enter RUN; src is high in the following tick.
REQ-014 SHALL use half-length H = NTAPS*S, or (NTAPS+2)*S when latched ilong=1; cycle length 2H ticks.
REQ-015 SHALL, in RUN at count c: src=1 iff c<H; tap[k]=1 iff (k+1)*S <= c < H+(k+1)*S.
REQ-016 SHALL increment c by 1 per tick in RUN; done=1 only on the tick where c=2H-1.
REQ-017 SHALL, at the edge ending c=2H-1: if hold=1 go to HOLD; else if start=1 restart c=0 with freshly latched S/ilong (no idle gap); else go to IDLE.
REQ-018 SHALL, in HOLD, drive src, tap, done low with busy=1; on hold=0 go to RUN (c=0, relatch) if start=1, else IDLE.
REQ-019 SHALL ignore speed and ilong changes during a cycle; values latched at cycle start only.
REQ-020 SHALL ignore start outside IDLE and cycle boundaries; deasserting start mid-cycle does not abort the cycle.
REQ-021 SHALL drive src, tap, done, busy low in IDLE.

Reset
REQ-022 SHALL, on reset=1 at an edge, enter IDLE, clear c, latched S, latched ilong, and drive src, tap, busy, done to 0 the following tick.
REQ-023 SHALL let reset take priority over every other input, including mid-cycle and in HOLD; no partial cycle resumes.
REQ-024 SHALL accept start on the first edge with reset=0.

Configuration
REQ-025 SHALL, with TAP_SEQUENCER_LONG_EN defined, honour ilong as in REQ-014.
REQ-026 SHALL, without TAP_SEQUENCER_LONG_EN, ignore ilong; H = NTAPS*S always, no ilong latch.

Verification
REQ-027 SHALL verify: NTAPS=5, speed=0, start pulse -> src high c0-4, tap[0] c1-5, tap[4] c5-9, done at c=9, busy 10 ticks, then IDLE.
REQ-028 SHALL verify: speed=3 -> S=4, H=20, tap[2] rises c=12, falls c=32, done at c=39.
REQ-029 SHALL verify: with LONG_EN, speed=1, ilong=1 -> H=14, cycle 28 ticks, done at c=27; without LONG_EN same stimulus -> H=10, done at c=19.
REQ-030 SHALL verify: start held high, speed=0 -> back-to-back cycles, src high again on the tick after done, speed change mid-cycle takes effect only in the next cycle.
REQ-031 SHALL verify: hold=1 at end of cycle for 7 ticks -> busy=1, src/tap low for 7 ticks, then restart if start=1.
REQ-032 SHALL verify: reset asserted at c=3 -> all outputs 0 the next tick, IDLE; start with reset=0 begins a fresh cycle at c=0.
